serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial subtractor: the subtract-direction counterpart of the team's full-adder cells.
//  Accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake.
//  Computes a - b - bin LSB-first, one bit per clock, through a full-subtractor cell
//  and a registered borrow. Presents difference and borrow-out through a valid/ready handshake.
//  Used where area matters more than latency, e.g. multi-cycle ALU and checksum paths.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst          in   1      reset, synchronous and active-high
//  start_valid  in   1      operands on a, b, bin are valid
//  start_ready  out  1      block can accept operands (high only in IDLE)
//  a            in   WIDTH  minuend
//  b            in   WIDTH  subtrahend
//  bin          in   1      borrow-in
//  diff         out  WIDTH  registered result (a - b - bin) mod 2^WIDTH
//  bout         out  1      registered borrow-out: 1 iff a < b + bin (unsigned)
//  done_valid   out  1      diff/bout hold a new result
//  done_ready   in   1      consumer accepts result
//  busy         out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, diff=0, bout=0, done_valid=0, busy=0, start_ready=1.
//   Shift registers, borrow flop and bit counter are cleared. Reset has priority over all inputs.
//  FSM states: IDLE, RUN, DONE.
//  IDLE: start_ready=1.
//   On start_valid=1 at an edge: latch a into sa, b into sb, bin into borrow flop br,
//   clear cnt, and go to RUN.
//  RUN: one bit per edge, with x=sa[0] and y=sb[0]:
//   d  = x ^ y ^ br
//   br <= (~x & y) | (~(x ^ y) & br)
//   sa, sb shift right; d shifts into MSB of partial-result register pr; cnt increments.
//   On the WIDTH-th RUN edge: diff<=final pr, bout<=final br, done_valid<=1, go to DONE.
//  DONE: done_valid=1. diff and bout remain stable until done_ready=1.
//   On done_ready=1 at an edge: done_valid<=0 and go to IDLE.
//  Latency: done_valid rises exactly WIDTH edges after the edge that accepted start.
//   Throughput is one operation per WIDTH+2 cycles at best.
//  Operand ports: a, b and bin are sampled only at the accepting edge. Later changes have no effect.
//  start_valid outside IDLE: ignored; no queueing. start_ready is low in RUN and DONE.
//  Same-edge done_ready and start_valid in DONE: only DONE->IDLE is taken.
//   The start is accepted on the next edge if still asserted.
//  diff/bout: change only on entry to DONE or on reset. They hold the last result in IDLE
//   and RUN; consumers qualify them with done_valid.
//  Reset mid-RUN or mid-DONE: the operation is aborted, no done_valid pulse, outputs cleared.
//  cnt width = clog2(WIDTH)+1; no wrap-around is reachable.
// TESTING
//  T1 basic: a=0x35, b=0x12, bin=0 -> diff=0x23, bout=0.
//   done_valid rises exactly 8 edges after the accept edge.
//  T2 underflow/borrow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
//   a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
//  T3 borrow-in propagation: a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0.
//   a=0x00, b=0x00, bin=0 -> diff=0x00, bout=0.
//  T4 backpressure: hold done_ready=0 for 5 cycles after done_valid.
//   Required: done_valid, diff and bout stay stable; start_valid pulsed in RUN/DONE is ignored
//   (start_ready=0 throughout); result matches the first operands.
//  T5 reset mid-operation: assert rst at the 3rd RUN edge.
//   Required: next cycle IDLE, diff=0, bout=0, busy=0, no done_valid.
//   A following op a=0x10, b=0x01 -> diff=0x0F, bout=0.
//  T6 back-to-back plus random: done_ready=1 and start_valid=1 held continuously.
//   Required: ops complete every WIDTH+2 cycles.
//   1000 random a/b/bin vs reference model (a-b-bin); also run with WIDTH=4 and WIDTH=16.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin with start/done valid-ready handshakes
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sa, sb, pr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             x, y, d, br_next, last_bit;
    logic [WIDTH-1:0] pr_next;

    // Full-subtractor cell on the current LSBs; the result bit enters pr from the top.
    always_comb begin
        x        = sa[0];
        y        = sb[0];
        d        = x ^ y ^ br;
        br_next  = (~x & y) | (~(x ^ y) & br);
        pr_next  = {d, pr[WIDTH-1:1]};
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (last_bit)    state_next = DONE;
            DONE:    if (done_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            pr         <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            bout       <= 1'b0;
            done_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= bin;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    pr  <= pr_next;
                    br  <= br_next;
                    cnt <= cnt + 1'b1;
                    // Results are published only on the final bit so they stay stable otherwise.
                    if (last_bit) begin
                        diff       <= pr_next;
                        bout       <= br_next;
                        done_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_ready) done_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at WIDTH 8, 4 and 16
module tb_serial_subtractor;

    localparam int WS [3] = '{8, 4, 16};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a8, b8;
    logic [3:0]  a4, b4;
    logic [15:0] a16, b16;
    logic        bin_s [3];
    logic        sv_s  [3];
    logic        dr_s  [3];
    wire         sr_s  [3];
    wire         dv_s  [3];
    wire         busy_s[3];
    wire         bout_s[3];
    wire  [7:0]  d8;
    wire  [3:0]  d4;
    wire  [15:0] d16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic        bo;
    } exp_t;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start_valid(sv_s[0]), .start_ready(sr_s[0]),
        .a(a8), .b(b8), .bin(bin_s[0]), .diff(d8), .bout(bout_s[0]),
        .done_valid(dv_s[0]), .done_ready(dr_s[0]), .busy(busy_s[0])
    );

    serial_subtractor #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start_valid(sv_s[1]), .start_ready(sr_s[1]),
        .a(a4), .b(b4), .bin(bin_s[1]), .diff(d4), .bout(bout_s[1]),
        .done_valid(dv_s[1]), .done_ready(dr_s[1]), .busy(busy_s[1])
    );

    serial_subtractor #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start_valid(sv_s[2]), .start_ready(sr_s[2]),
        .a(a16), .b(b16), .bin(bin_s[2]), .diff(d16), .bout(bout_s[2]),
        .done_valid(dv_s[2]), .done_ready(dr_s[2]), .busy(busy_s[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on unsigned operands.
    function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                   input logic bi);
        exp_t e;
        int full;
        full = int'(av) - int'(bv) - (bi ? 1 : 0);
        e.d  = 16'(full & ((1 << w) - 1));
        e.bo = (int'(av) < int'(bv) + (bi ? 1 : 0));
        return e;
    endfunction

    function automatic logic [15:0] rnd(input int w);
        int          r;
        logic [15:0] m;
        r = int'($urandom_range(0, 7));
        m = 16'((1 << w) - 1);
        case (r)
            0:       return 16'h0;
            1:       return m;
            default: return 16'($urandom) & m;
        endcase
    endfunction

    task automatic set_ops(input int k, input logic [15:0] av, input logic [15:0] bv, input logic bi);
        case (k)
            0:       begin a8 = av[7:0]; b8 = bv[7:0]; end
            1:       begin a4 = av[3:0]; b4 = bv[3:0]; end
            default: begin a16 = av; b16 = bv; end
        endcase
        bin_s[k] = bi;
    endtask

    function automatic logic [15:0] get_diff(input int k);
        case (k)
            0:       return {8'h0, d8};
            1:       return {12'h0, d4};
            default: return d16;
        endcase
    endfunction

    task automatic run_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic bi, input string name);
        exp_t e;
        int   lat;
        e = model(WS[k], av, bv, bi);
        set_ops(k, av, bv, bi);
        sv_s[k] = 1'b1;
        checks++;
        if (sr_s[k] !== 1'b1) begin
            errors++; $display("FAIL %s start_ready: got %b want 1", name, sr_s[k]);
        end
        tick();
        sv_s[k] = 1'b0;
        set_ops(k, rnd(WS[k]), rnd(WS[k]), 1'($urandom));
        lat = 0;
        while (dv_s[k] !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != WS[k]) begin
            errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, WS[k]);
        end
        checks++;
        if (get_diff(k) !== e.d) begin
            errors++; $display("FAIL %s diff: got %h want %h", name, get_diff(k), e.d);
        end
        checks++;
        if (bout_s[k] !== e.bo) begin
            errors++; $display("FAIL %s bout: got %b want %b", name, bout_s[k], e.bo);
        end
        dr_s[k] = 1'b1;
        tick();
        dr_s[k] = 1'b0;
        checks++;
        if (dv_s[k] !== 1'b0 || sr_s[k] !== 1'b1) begin
            errors++; $display("FAIL %s release: got dv=%b sr=%b want dv=0 sr=1", name, dv_s[k], sr_s[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({sr_s[k], dv_s[k], busy_s[k], bout_s[k]} !== 4'b1000 || get_diff(k) !== 16'h0) begin
                errors++;
                $display("FAIL reset w%0d: got sr=%b dv=%b busy=%b bout=%b diff=%h want 1 0 0 0 0000",
                         WS[k], sr_s[k], dv_s[k], busy_s[k], bout_s[k], get_diff(k));
            end
        end
    endtask

    task automatic test_basic();
        run_op(0, 16'h35, 16'h12, 1'b0, "basic_35_12");
    endtask

    task automatic test_borrow();
        run_op(0, 16'h00, 16'h01, 1'b0, "underflow_00_01");
        run_op(0, 16'hFF, 16'hFF, 1'b1, "borrow_ff_ff_1");
    endtask

    task automatic test_borrow_in();
        run_op(0, 16'h80, 16'h7F, 1'b1, "bin_80_7f_1");
        run_op(0, 16'h00, 16'h00, 1'b0, "zero_00_00");
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        e = model(8, 16'h5A, 16'h3C, 1'b1);
        set_ops(0, 16'h5A, 16'h3C, 1'b1);
        sv_s[0] = 1'b1;
        tick();
        set_ops(0, 16'h01, 16'hF0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sr_s[0] !== 1'b0) begin
                errors++; $display("FAIL bp_run_ready: got %b want 0", sr_s[0]);
            end
            tick();
        end
        sv_s[0] = 1'b0;
        n = 0;
        while (dv_s[0] !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            sv_s[0] = i[0];
            checks++;
            if (dv_s[0] !== 1'b1 || sr_s[0] !== 1'b0 || get_diff(0) !== e.d || bout_s[0] !== e.bo) begin
                errors++;
                $display("FAIL bp_hold%0d: got dv=%b sr=%b diff=%h bout=%b want 1 0 %h %b",
                         i, dv_s[0], sr_s[0], get_diff(0), bout_s[0], e.d, e.bo);
            end
            tick();
        end
        // Same-edge release and start: only DONE->IDLE, start accepted one edge later.
        e = model(8, 16'h12, 16'h34, 1'b0);
        set_ops(0, 16'h12, 16'h34, 1'b0);
        sv_s[0] = 1'b1;
        dr_s[0] = 1'b1;
        tick();
        dr_s[0] = 1'b0;
        checks++;
        if (busy_s[0] !== 1'b0 || dv_s[0] !== 1'b0) begin
            errors++; $display("FAIL same_edge_idle: got busy=%b dv=%b want 0 0", busy_s[0], dv_s[0]);
        end
        tick();
        sv_s[0] = 1'b0;
        checks++;
        if (busy_s[0] !== 1'b1) begin
            errors++; $display("FAIL same_edge_accept: got busy=%b want 1", busy_s[0]);
        end
        n = 0;
        while (dv_s[0] !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (get_diff(0) !== e.d || bout_s[0] !== e.bo) begin
            errors++; $display("FAIL same_edge_result: got %h/%b want %h/%b", get_diff(0), bout_s[0], e.d, e.bo);
        end
        dr_s[0] = 1'b1;
        tick();
        dr_s[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        set_ops(0, 16'hAA, 16'h11, 1'b0);
        sv_s[0] = 1'b1;
        tick();
        sv_s[0] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy_s[0] !== 1'b0 || sr_s[0] !== 1'b1 || dv_s[0] !== 1'b0 ||
            get_diff(0) !== 16'h0 || bout_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b sr=%b dv=%b diff=%h bout=%b want 0 1 0 0000 0",
                     busy_s[0], sr_s[0], dv_s[0], get_diff(0), bout_s[0]);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (dv_s[0] === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", seen);
        end
        run_op(0, 16'h10, 16'h01, 1'b0, "after_reset_10_01");
    endtask

    task automatic test_back_to_back(input int k, input int nops);
        exp_t        q[$];
        exp_t        e;
        logic [15:0] av, bv;
        logic        bi;
        int          cyc, last, ndone, gap_err, res_err;
        av = rnd(WS[k]); bv = rnd(WS[k]); bi = 1'($urandom);
        set_ops(k, av, bv, bi);
        sv_s[k] = 1'b1;
        dr_s[k] = 1'b1;
        cyc = 0; last = -1; ndone = 0; gap_err = 0; res_err = 0;
        while (ndone < nops && cyc < nops * (WS[k] + 2) + 100) begin
            if (sr_s[k] === 1'b1) q.push_back(model(WS[k], av, bv, bi));
            tick();
            cyc++;
            av = rnd(WS[k]); bv = rnd(WS[k]); bi = 1'($urandom);
            set_ops(k, av, bv, bi);
            if (dv_s[k] === 1'b1) begin
                if (q.size() == 0) begin
                    res_err++;
                    $display("FAIL b2b_w%0d_spurious: got done_valid with no accepted op", WS[k]);
                end else begin
                    e = q.pop_front();
                    if (get_diff(k) !== e.d || bout_s[k] !== e.bo) begin
                        res_err++;
                        if (res_err < 5)
                            $display("FAIL b2b_w%0d_result: got %h/%b want %h/%b",
                                     WS[k], get_diff(k), bout_s[k], e.d, e.bo);
                    end
                end
                if (last >= 0 && cyc - last != WS[k] + 2) begin
                    gap_err++;
                    if (gap_err < 5)
                        $display("FAIL b2b_w%0d_gap: got %0d want %0d", WS[k], cyc - last, WS[k] + 2);
                end
                last = cyc;
                ndone++;
            end
        end
        sv_s[k] = 1'b0;
        tick();
        dr_s[k] = 1'b0;
        checks++;
        if (ndone != nops) begin
            errors++; $display("FAIL b2b_w%0d_count: got %0d want %0d", WS[k], ndone, nops);
        end
        checks++;
        if (res_err != 0) begin
            errors++; $display("FAIL b2b_w%0d_results: got %0d bad want 0", WS[k], res_err);
        end
        checks++;
        if (gap_err != 0) begin
            errors++; $display("FAIL b2b_w%0d_gaps: got %0d bad want 0", WS[k], gap_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sv_s[k] = 1'b0;
            dr_s[k] = 1'b0;
            set_ops(k, 16'h0, 16'h0, 1'b0);
        end
        test_reset();
        test_basic();
        test_borrow();
        test_borrow_in();
        test_backpressure();
        test_reset_mid();
        test_back_to_back(0, 1000);
        test_back_to_back(1, 300);
        test_back_to_back(2, 300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
